// File: rtl/ttl_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ttl_counter_pkg
//  Description : Shared types and default sizes for the TTL-style counter
//                family (direction encoding, default width and reset value).
//  Revision    : 1.0 - initial release
// ============================================================================
package ttl_counter_pkg;

    // Count direction, matching the polarity of the 'direction' pin.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } cnt_dir_e;

    // Defaults chosen to match the legacy 9-bit TTL counter models.
    localparam int CNT_WIDTH_DEFAULT     = 9;
    localparam int CNT_RESET_VAL_DEFAULT = 0;

endpackage : ttl_counter_pkg
`default_nettype wire

// File: rtl/cen_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : cen_edge_detect
//  Description : Rising-edge detector for the count strobe. Produces a
//                single-clk 'tick' when 'cen' is high and was low on the
//                previous clk. The history register resets high so a strobe
//                held high through reset does not fire on release.
//  Revision    : 1.0 - initial release
// ============================================================================
module cen_edge_detect (
    input  logic clk,
    input  logic Reset,
    input  logic cen,
    output logic tick
);

    logic cen_d_q;

    // Remember the previous strobe level; reset to 1 to suppress a tick on release.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cen_d_q <= 1'b1;
        end else begin
            cen_d_q <= cen;
        end
    end

    assign tick = cen & ~cen_d_q;

endmodule : cen_edge_detect
`default_nettype wire

// File: rtl/nbit_bounded_counter.sv
`default_nettype none
// ============================================================================
//  Module      : nbit_bounded_counter
//  Description : Loadable up/down counter with programmable low/high bounds,
//                74LS-style load_n/ent_n/enp_n controls, combinational ripple
//                carry (rco) and a registered terminal-count pulse (tc).
//                Bounds are compared by equality only, so an out-of-range
//                count keeps stepping modulo 2^WIDTH until it meets a bound.
//  Config      : NBIT_COUNTER_CEN_EDGE_EN - when defined, ticks are rising
//                edges of 'cen'; otherwise 'cen' is a level clock-enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module nbit_bounded_counter
    import ttl_counter_pkg::*;
#(
    parameter int               WIDTH     = CNT_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(CNT_RESET_VAL_DEFAULT),
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             cen,
    input  logic             direction,
    input  logic             load_n,
    input  logic             ent_n,
    input  logic             enp_n,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             tc
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;

    logic             w_tick;
    cnt_dir_e         w_dir;
    logic             w_at_hi;
    logic             w_at_lo;
    logic             w_bound_hit;
    logic             w_count_en;

`ifdef NBIT_COUNTER_CEN_EDGE_EN
    // Ticks are cen rising edges seen in the clk domain.
    cen_edge_detect u_cen_edge_detect (
        .clk   (clk),
        .Reset (Reset),
        .cen   (cen),
        .tick  (w_tick)
    );
`else
    // Plain level enable: every clk with cen high is a tick.
    assign w_tick = cen;
`endif

    assign w_dir       = cnt_dir_e'(direction);
    assign w_at_hi     = (q_q == hi);
    assign w_at_lo     = (q_q == lo);
    // The bound that matters depends on which way we are heading.
    assign w_bound_hit = (w_dir == DIR_UP) ? w_at_hi : w_at_lo;
    assign w_count_en  = ~ent_n & ~enp_n;

    // Next count and terminal-count pulse: load beats count, count beats hold.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (w_tick) begin
            if (!load_n) begin
                q_d = P;
            end else if (w_count_en) begin
                if (w_bound_hit) begin
                    tc_d = 1'b1;
                    if (!SATURATE) begin
                        q_d = (w_dir == DIR_UP) ? lo : hi;
                    end
                end else begin
                    q_d = (w_dir == DIR_UP) ? (q_q + 1'b1) : (q_q - 1'b1);
                end
            end
        end
    end

    // Count and tc registers; reset wins over any simultaneous tick.
    always_ff @(posedge clk) begin
        if (Reset) begin
            q_q  <= RESET_VAL;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    // Ripple carry ignores cen/enp_n/load_n so chained stages see it early.
    assign rco = ~ent_n & w_bound_hit;
    assign Q   = q_q;
    assign tc  = tc_q;

endmodule : nbit_bounded_counter
`default_nettype wire

// File: tb/tb_nbit_bounded_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nbit_bounded_counter
//  Description : Directed self-checking bench for nbit_bounded_counter. A
//                wrapping and a saturating instance share all inputs; each
//                step pushes the expected outputs of both and checks them
//                after the clk edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_bounded_counter;

`ifdef NBIT_COUNTER_CEN_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       Reset;
    logic       cen;
    logic       direction;
    logic       load_n;
    logic       ent_n;
    logic       enp_n;
    logic [8:0] P;
    logic [8:0] lo;
    logic [8:0] hi;
    logic [8:0] Q;
    logic       rco;
    logic       tc;
    logic [8:0] Q_s;
    logic       rco_s;
    logic       tc_s;

    always #5 clk = ~clk;

    nbit_bounded_counter #(.WIDTH(9), .RESET_VAL(9'd0), .SATURATE(1'b0)) u_dut (
        .clk(clk), .Reset(Reset), .cen(cen), .direction(direction),
        .load_n(load_n), .ent_n(ent_n), .enp_n(enp_n),
        .P(P), .lo(lo), .hi(hi), .Q(Q), .rco(rco), .tc(tc)
    );

    nbit_bounded_counter #(.WIDTH(9), .RESET_VAL(9'd0), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .Reset(Reset), .cen(cen), .direction(direction),
        .load_n(load_n), .ent_n(ent_n), .enp_n(enp_n),
        .P(P), .lo(lo), .hi(hi), .Q(Q_s), .rco(rco_s), .tc(tc_s)
    );

    typedef struct {
        string      tag;
        logic [8:0] q;
        logic       tc;
        logic       rco;
        logic [8:0] qs;
        logic       tcs;
        logic       rcos;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
        end
    endtask

    // One clk: drive cen at negedge, queue expectations, check after posedge.
    task automatic step(input string tag, input logic c,
                        input logic [8:0] q,  input logic t,  input logic r,
                        input logic [8:0] qs, input logic ts, input logic rs);
        exp_t e;
        @(negedge clk);
        cen = c;
        e.tag = tag; e.q = q; e.tc = t; e.rco = r;
        e.qs = qs; e.tcs = ts; e.rcos = rs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk(e.tag, "Q",     {23'd0, Q},   {23'd0, e.q});
            chk(e.tag, "tc",    {31'd0, tc},  {31'd0, e.tc});
            chk(e.tag, "rco",   {31'd0, rco}, {31'd0, e.rco});
            chk(e.tag, "Q_sat", {23'd0, Q_s}, {23'd0, e.qs});
            chk(e.tag, "tc_sat",  {31'd0, tc_s},  {31'd0, e.tcs});
            chk(e.tag, "rco_sat", {31'd0, rco_s}, {31'd0, e.rcos});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; cen = 1'b1; direction = 1'b1;
        load_n = 1'b1; ent_n = 1'b0; enp_n = 1'b0;
        P = 9'd0; lo = 9'd0; hi = 9'h1FF;

        // Reset with cen held high.
        step("rst0", 1'b1, 9'd0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
        step("rst1", 1'b1, 9'd0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);

        // Release with cen still high: only a level enable counts here.
        Reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step("rel_hold", 1'b1, EDGE ? 9'd0 : 9'(k), 1'b0, 1'b0,
                 EDGE ? 9'd0 : 9'(k), 1'b0, 1'b0);
        end

        // Reset again with cen low, then hold cen high for 5 clk.
        Reset = 1'b1;
        step("rst2", 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
        Reset = 1'b0;
        step("idle", 1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step("cen5", 1'b1, EDGE ? 9'd1 : 9'(k), 1'b0, 1'b0,
                 EDGE ? 9'd1 : 9'(k), 1'b0, 1'b0);
        end
        step("cen5_lo", 1'b0, EDGE ? 9'd1 : 9'd5, 1'b0, 1'b0,
             EDGE ? 9'd1 : 9'd5, 1'b0, 1'b0);

        // Up wrap at hi=0x1FF back to lo=0x080.
        lo = 9'h080; hi = 9'h1FF; direction = 1'b1;
        load_n = 1'b0; P = 9'h1FE;
        step("ld1FE", 1'b1, 9'h1FE, 1'b0, 1'b0, 9'h1FE, 1'b0, 1'b0);
        load_n = 1'b1;
        step("ld1FE_gap", 1'b0, 9'h1FE, 1'b0, 1'b0, 9'h1FE, 1'b0, 1'b0);
        step("up_1FF", 1'b1, 9'h1FF, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b1);
        step("up_1FF_gap", 1'b0, 9'h1FF, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b1);
        step("up_wrap", 1'b1, 9'h080, 1'b1, 1'b0, 9'h1FF, 1'b1, 1'b1);
        step("up_wrap_gap", 1'b0, 9'h080, 1'b0, 1'b0, 9'h1FF, 1'b0, 1'b1);

        // Down wrap at lo=0x010 to hi=0x0FF.
        direction = 1'b0; lo = 9'h010; hi = 9'h0FF;
        load_n = 1'b0; P = 9'h010;
        step("ld010", 1'b1, 9'h010, 1'b0, 1'b1, 9'h010, 1'b0, 1'b1);
        load_n = 1'b1;
        step("ld010_gap", 1'b0, 9'h010, 1'b0, 1'b1, 9'h010, 1'b0, 1'b1);
        step("dn_wrap", 1'b1, 9'h0FF, 1'b1, 1'b0, 9'h010, 1'b1, 1'b1);
        step("dn_wrap_gap", 1'b0, 9'h0FF, 1'b0, 1'b0, 9'h010, 1'b0, 1'b1);
        step("dn_step", 1'b1, 9'h0FE, 1'b0, 1'b0, 9'h010, 1'b1, 1'b1);
        step("dn_step_gap", 1'b0, 9'h0FE, 1'b0, 1'b0, 9'h010, 1'b0, 1'b1);

        // Load has priority over counting; out-of-range value keeps counting.
        load_n = 1'b0; P = 9'h1AB;
        step("ld1AB", 1'b1, 9'h1AB, 1'b0, 1'b0, 9'h1AB, 1'b0, 1'b0);
        load_n = 1'b1;
        step("ld1AB_gap", 1'b0, 9'h1AB, 1'b0, 1'b0, 9'h1AB, 1'b0, 1'b0);
        step("oor_dn", 1'b1, 9'h1AA, 1'b0, 1'b0, 9'h1AA, 1'b0, 1'b0);
        step("oor_dn_gap", 1'b0, 9'h1AA, 1'b0, 1'b0, 9'h1AA, 1'b0, 1'b0);

        // enp_n/ent_n gating and rco.
        direction = 1'b1;
        load_n = 1'b0; P = 9'h0FF;
        step("ld0FF", 1'b1, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b1);
        load_n = 1'b1; enp_n = 1'b1;
        step("enp_gap", 1'b0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b1);
        step("enp_hold", 1'b1, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b1);
        step("enp_hold_gap", 1'b0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b1);
        ent_n = 1'b1; enp_n = 1'b0;
        step("ent_hold", 1'b1, 9'h0FF, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0);
        step("ent_hold_gap", 1'b0, 9'h0FF, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_nbit_bounded_counter
`default_nettype wire

// File: doc/nbit_bounded_counter.md
# nbit_bounded_counter

Parametrised, loadable up/down counter with programmable low/high wrap bounds, terminal-count outputs and an optional saturate mode. It generalises the team's fixed 9-bit TTL counter models so one block can serve sprite/tile address counters and video line/pixel counters with non-power-of-two ranges. It keeps 74LS-style `load_n`/`ent_n`/`enp_n` semantics, and the cascade output allows chaining into wider counters.

## Interface
- `WIDTH`, 9: counter width in bits, 2..32.
- `RESET_VAL`, 0: value loaded into `Q` by reset.
- `SATURATE`, 0: 0 = wrap at bounds, 1 = hold at bounds.

- `clk` in 1: the single clock for the block.
- `Reset` in 1: synchronous, active-high reset.
- `cen` in 1: count/load strobe, qualified per Configuration.
- `direction` in 1: 1 = up, 0 = down.
- `load_n` in 1: 0 = load `P` on a tick. Has priority over counting.
- `ent_n` in 1: active-low enable T. Also gates `rco`.
- `enp_n` in 1: active-low enable P.
- `P` in WIDTH: parallel load value.
- `lo` in WIDTH: lower bound. Quasi-static.
- `hi` in WIDTH: upper bound. Quasi-static. Requires `lo` ≤ `hi`.
- `Q` out WIDTH: current count.
- `rco` out 1: combinational ripple carry.
- `tc` out 1: registered one-`clk` pulse when a bound is hit on a count tick.

## Operation
- Tick:
  - With edge detection enabled, a tick occurs on any `clk` edge where `cen` = 1 and `cen_d` = 0.
  - `cen_d` is `cen` registered every `clk`.
- Per tick, in priority order:
  - `load_n` = 0: `Q` ← `P`, verbatim. No range clamp. `tc` stays 0.
  - Else, if `ent_n` = 0 and `enp_n` = 0, count:
    - Up and `Q` == `hi`: `Q` ← `lo`, or holds if `SATURATE`. `tc` ← 1.
    - Up, otherwise: `Q` ← `Q` + 1, modulo 2^WIDTH.
    - Down and `Q` == `lo`: `Q` ← `hi`, or holds if `SATURATE`. `tc` ← 1.
    - Down, otherwise: `Q` ← `Q` − 1, modulo 2^WIDTH.
  - Else: hold.
- Out-of-range values (loaded or after a bound change): bound checks are equality only.
  - Counting continues modulo 2^WIDTH until the count reaches the active bound.
- `rco` = `~ent_n` & (`direction` ? `Q` == `hi` : `Q` == `lo`).
  - Independent of `cen`, `enp_n` and `load_n`, as in 74LS163 cascading.
- `tc` is 0 on every `clk` that is not a bound-hit tick.
- Reset:
  - `Q` ← `RESET_VAL`.
  - `cen_d` ← 1, so a `cen` held high through reset produces no tick on release.
  - `tc` ← 0.
  - `rco` follows the reset `Q`.
  - Reset overrides any simultaneous tick.

## Timing
- `Q` and `tc` update on the `clk` edge at which the tick is detected.
  - The new values are visible one `clk` after `cen` is sampled high.
- `rco` is combinational from `Q`, `ent_n`, `direction`, `lo` and `hi`. Zero latency.
- Minimum tick spacing with edge detection: 2 `clk` (`cen` must be seen low between ticks).
- Reset mid-count: the count is lost. The first tick after release needs a fresh `cen` rising edge.
- `lo`/`hi` changes take effect on the next tick. There is no registered copy.

## Configuration
- `NBIT_COUNTER_CEN_EDGE_EN` defined:
  - Ticks are `cen` rising edges, detected in the `clk` domain.
  - Compatible with existing TTL models driven by divided-clock enables.
- Not defined:
  - `cen` is a plain level clock-enable. Every `clk` with `cen` = 1 is a tick.
  - `cen_d` is not built. Reset behaviour is otherwise unchanged.

## Structure
- Shared package `ttl_counter_pkg`:
  - `cnt_dir_e` (`DIR_DOWN` = 0, `DIR_UP` = 1).
  - Localparam defaults for `WIDTH` and `RESET_VAL`.
- One sub-module: `cen_edge_detect` (`clk`, `Reset`, `cen` → `tick`).
  - Instantiated only under `NBIT_COUNTER_CEN_EDGE_EN`.
  - Otherwise `tick` = `cen`.
- Bound compare and next-value logic stay in the top module.

## Test plan
- Reset with `cen` held 1, then release: `Q` = `RESET_VAL` (0). No count until `cen` goes 0→1. `tc` = 0 throughout.
- `WIDTH`=9, `lo`=0x080, `hi`=0x1FF, up, `Q`=0x1FE, two ticks: `Q` = 0x1FF, then 0x080. `tc` pulses 1 `clk` on the second tick. `rco` = 1 only while `Q` = 0x1FF.
- Down, `lo`=0x010, `hi`=0x0FF, `Q`=0x010, one tick: `Q` = 0x0FF. With `SATURATE`=1, `Q` stays 0x010 and `tc` still pulses.
- `load_n`=0, `P`=0x1AB, `ent_n`=`enp_n`=0 on a tick: `Q` = 0x1AB. No increment. `tc` = 0.
- `enp_n`=1, `ent_n`=0, `Q`=`hi`: ticks leave `Q` unchanged and `rco` = 1. With `ent_n`=1, `rco` = 0.
- Without `NBIT_COUNTER_CEN_EDGE_EN`, `cen` held 1 for 5 `clk` from `Q`=0, up: `Q` = 5. With the macro defined, the same stimulus gives `Q` = 1.
